// File: rtl/frame_filter_engine.sv
// Frame-buffered pixel filter: capture one frame, then stream it out
// as passthrough, threshold, 3x3 median (edge clamped) or invert.
module frame_filter_engine #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] thresh,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_data,
  output logic             frame_done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_PROC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [PIX_W-1:0] MAXV = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [PIX_W-1:0]  thr_q, thr_d;
  logic              out_valid_q, out_valid_d;
  logic [PIX_W-1:0]  out_data_q, out_data_d;

  logic [PIX_W-1:0]  mem [0:(2**ADDR_W)-1];
  logic [PIX_W-1:0]  rd_q;
  logic [PIX_W-1:0]  taps_q [0:8];
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic              cap_en;
  logic              is_med;
  logic [3:0]        ntaps;
  logic [3:0]        tap_idx;
  logic [PIX_W-1:0]  one_res;
  logic [PIX_W-1:0]  med;
  int                tr, tc, rank;

  assign is_med  = (mode_q == 2'b10);
  assign ntaps   = is_med ? 4'd9 : 4'd1;
  assign tap_idx = cnt_q - 4'd1;

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && in_valid) mem[wr_cnt_q] <= in_data;
    if (rd_en) rd_q <= mem[rd_addr];
    if (cap_en) taps_q[tap_idx] <= rd_q;
  end

  // Median taps walk the 3x3 window; coordinates clamp at frame edges.
  always_comb begin
    tr = int'(row_q);
    tc = int'(col_q);
    if (is_med) begin
      tr = int'(row_q) + int'(cnt_q) / 3 - 1;
      tc = int'(col_q) + int'(cnt_q) % 3 - 1;
      if (tr < 0) tr = 0;
      if (tr > HEIGHT - 1) tr = HEIGHT - 1;
      if (tc < 0) tc = 0;
      if (tc > WIDTH - 1) tc = WIDTH - 1;
    end
    rd_addr = ADDR_W'(tr * WIDTH + tc);
  end

  always_comb begin
    unique case (mode_q)
      2'b01:   one_res = (rd_q >= thr_q) ? MAXV : '0;
      2'b11:   one_res = MAXV - rd_q;
      default: one_res = rd_q;
    endcase
  end

  // Rank each tap (ties broken by position); rank 4 is the median.
  always_comb begin
    med  = '0;
    rank = 0;
    for (int i = 0; i < 9; i++) begin
      rank = 0;
      for (int j = 0; j < 9; j++) begin
        if (taps_q[j] < taps_q[i] ||
            (taps_q[j] == taps_q[i] && j < i))
          rank = rank + 1;
      end
      if (rank == 4) med = taps_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_en       = 1'b0;
    cap_en      = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == ADDR_W'(NPIX - 1)) begin
            state_d  = S_PROC;
            wr_cnt_d = '0;
            mode_d   = mode;
            thr_d    = thresh;
            row_d    = '0;
            col_d    = '0;
            cnt_d    = '0;
          end
        end
      end
      S_PROC: begin
        if (out_valid_q) begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            cnt_d       = '0;
            if (row_q == ADDR_W'(HEIGHT - 1) &&
                col_q == ADDR_W'(WIDTH - 1)) begin
              state_d = S_DONE;
            end else if (col_q == ADDR_W'(WIDTH - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          rd_en = (cnt_q < ntaps);
          cap_en = is_med && cnt_q >= 4'd1 && cnt_q <= 4'd9;
          if (!is_med && cnt_q == 4'd1) begin
            out_data_d  = one_res;
            out_valid_d = 1'b1;
          end
          if (is_med && cnt_q == 4'd10) begin
            out_data_d  = med;
            out_valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d  = S_LOAD;
        wr_cnt_d = '0;
        row_d    = '0;
        col_d    = '0;
        cnt_d    = '0;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      thr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = (state_q == S_DONE);
  assign state      = state_q;

endmodule

// File: tb/tb_frame_filter_engine.sv
// Randomized bench for frame_filter_engine on a 4x4 frame,
// checked against a behavioural frame model.
module tb_frame_filter_engine;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] thresh;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       frame_done;
  logic [1:0] st;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mdl [N];

  frame_filter_engine #(
    .WIDTH(W), .HEIGHT(H), .PIX_W(8), .ADDR_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .thresh(thresh),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .frame_done(frame_done),
    .state(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int ref_out(input int m, input int t, input int idx);
    int r, c, k, tmp;
    int v [9];
    r = idx / W;
    c = idx % W;
    case (m)
      1: return (mdl[idx] >= t) ? 255 : 0;
      3: return 255 - mdl[idx];
      2: begin
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            v[k] = mdl[clampi(r + dr, 0, H - 1) * W +
                       clampi(c + dc, 0, W - 1)];
            k++;
          end
        for (int a = 0; a < 9; a++)
          for (int b = 0; b < 8 - a; b++)
            if (v[b] > v[b + 1]) begin
              tmp = v[b]; v[b] = v[b + 1]; v[b + 1] = tmp;
            end
        return v[4];
      end
      default: return mdl[idx];
    endcase
  endfunction

  // kind: 0 ramp, 1 flat 10 with 200 at (2,2), 2 100.., 3 random
  task automatic load_frame(input int kind, input int m, input int t);
    int p;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      check("in_ready_load", in_ready, 1);
      case (kind)
        0: p = i;
        1: p = (i == 2 * W + 2) ? 200 : 10;
        2: p = 100 + i;
        default: p = $urandom_range(0, 255);
      endcase
      mdl[i] = p;
      in_valid = 1'b1;
      in_data = 8'(p);
      if (i == N - 1) begin
        mode = 2'(m);
        thresh = 8'(t);
      end
      tick();
    end
    in_valid = 1'b0;
    mode = 2'($urandom_range(0, 3));
    thresh = 8'($urandom);
    check("enter_proc", st, 1);
    check("in_ready_proc", in_ready, 0);
  endtask

  // rmode: 0 ready high, 1 random, 2 toggle, 3 five-cycle stall
  task automatic collect(input int m, input int t, input int rmode,
                         input int abort_after, input int pulses);
    int n, fstart, lat, lowleft, guard;
    bit pv, phs, hs, r;
    logic [7:0] pd;
    n = 0;
    fstart = cyc;
    lat = (m == 2) ? 11 : 2;
    lowleft = (rmode == 3) ? 5 : 0;
    pv = 1'b0;
    phs = 1'b0;
    pd = '0;
    guard = 0;
    while (n < N && guard < 3000) begin
      if (pulses != 0) begin
        in_valid = 1'($urandom);
        in_data = 8'($urandom);
        mode = 2'($urandom_range(0, 3));
      end
      case (rmode)
        0: r = 1'b1;
        1: r = 1'($urandom);
        2: r = 1'(cyc % 2);
        default: begin
          if (out_valid && lowleft > 0) begin
            r = 1'b0;
            lowleft--;
          end else r = 1'b1;
        end
      endcase
      out_ready = r;
      if (frame_done) check("early_done", frame_done, 0);
      if (out_valid && !pv) check("latency", cyc - fstart, lat);
      if (pv && !phs) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pd);
      end
      hs = out_valid && r;
      if (hs) begin
        check($sformatf("m%0d_pix%0d", m, n), out_data, ref_out(m, t, n));
        n++;
        fstart = cyc + 1;
      end
      pv = out_valid;
      pd = out_data;
      phs = hs;
      if (hs && n == abort_after) begin
        tick();
        reset = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_state", st, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_done", frame_done, 0);
        return;
      end
      tick();
      guard++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    if (n < N) begin
      check("timeout_pixels", n, N);
    end else begin
      check("done_pulse", frame_done, 1);
      check("done_state", st, 2);
      tick();
      check("back_load", st, 0);
      check("done_drop", frame_done, 0);
      check("ready_back", in_ready, 1);
    end
  endtask

  task automatic run_frame(input int kind, input int m, input int t,
                           input int rmode, input int pulses);
    load_frame(kind, m, t);
    collect(m, t, rmode, 0, pulses);
  endtask

  initial begin
    reset = 1'b1;
    mode = '0;
    thresh = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset_state", st, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_done", frame_done, 0);
    reset = 1'b0;
    tick();

    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 1, 8, 0, 0);
    run_frame(0, 3, 0, 0, 0);
    run_frame(0, 2, 0, 0, 0);
    run_frame(1, 2, 0, 0, 0);
    run_frame(0, 0, 0, 3, 0);
    run_frame(3, 2, 0, 2, 0);
    run_frame(3, 0, 0, 2, 0);

    load_frame(0, 0, 0);
    collect(0, 0, 0, 6, 0);
    run_frame(2, 0, 0, 0, 0);

    run_frame(0, 0, 0, 1, 1);
    run_frame(3, 2, 0, 1, 1);

    for (int k = 0; k < 6; k++) begin
      int m, t;
      m = $urandom_range(0, 3);
      t = $urandom_range(0, 255);
      run_frame(3, m, t, $urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_filter_engine.md
# frame_filter_engine

Parametrised frame-buffered pixel processor for the UART image path. It captures one WIDTH×HEIGHT frame from the receive stream into internal block RAM, then streams the processed frame out under transmitter backpressure. The mode is selectable per frame: passthrough, threshold, 3×3 median with edge clamping, or invert. It replaces the fixed 64×64 threshold/median processor between the UART receiver and transmitter.

## Interface
- WIDTH, 64, frame width in pixels (≥2)
- HEIGHT, 64, frame height in pixels (≥2)
- PIX_W, 8, pixel width in bits
- ADDR_W, 12, RAM address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- mode  in  2  00 passthrough, 01 threshold, 10 median 3×3, 11 invert; latched on LOAD→PROC
- thresh  in  PIX_W  threshold level, latched with mode
- in_valid  in  1  receive pixel strobe (valid_rx)
- in_data  in  PIX_W  receive pixel (data_rx)
- in_ready  out  1  high only in LOAD
- out_ready  in  1  transmitter ready (ready_tx)
- out_valid  out  1  out_data holds a result
- out_data  out  PIX_W  processed pixel
- frame_done  out  1  one-cycle pulse after the last output handshake
- state  out  2  00 LOAD, 01 PROC, 10 DONE (debug LEDs)

## Operation
- Reset values: state=LOAD, in_ready=1, out_valid=0, out_data=0, frame_done=0; write and read counters=0. RAM contents are not cleared.
- LOAD: each cycle with in_valid=1 writes in_data to address wr_cnt, raster order, then wr_cnt increments.
  - The write of pixel WIDTH*HEIGHT-1 moves the state to PROC on the next cycle.
  - mode and thresh are latched on that same edge.
  - in_valid outside LOAD is ignored and does not write the RAM.
- PROC: pixels are processed in raster order (row r, col c), one at a time.
  - Fetch: read the required taps. Modes 00/01/11 need 1 tap (r,c). Mode 10 needs 9 taps.
  - Compute: register the result into out_data and raise out_valid.
  - Hold: out_data and out_valid stay stable until out_valid & out_ready.
  - After a handshake, out_valid drops the next cycle and the fetch for the next pixel starts that same cycle.
  - The handshake on the last pixel moves the state to DONE.
- DONE: lasts one cycle with frame_done=1, then returns to LOAD with counters at 0.
- Arithmetic (unsigned, MAX=2^PIX_W-1):
  - passthrough: out = p
  - threshold: out = (p ≥ thresh) ? MAX : 0
  - invert: out = MAX−p
  - median: out = 5th smallest of the 9 taps
- Median taps: rows r−1..r+1, cols c−1..c+1. Out-of-frame coordinates are clamped to [0,HEIGHT−1]/[0,WIDTH−1] (edge replication); they never wrap. Address = row*WIDTH+col, computed without truncation.
- A mode change during PROC has no effect until the next frame.

## Timing
- RAM: simple dual-port. Write port is used in LOAD; read port has 1-cycle latency.
- Per-pixel latency from the fetch-start cycle F to out_valid high:
  - modes 00/01/11: out_valid at F+2 (address at F, data at F+1, registered result at F+2).
  - mode 10: tap addresses at F..F+8, data at F+1..F+9, median registered so out_valid is at F+11.
- With out_ready held high, throughput is one pixel per 3 cycles (single-tap modes) or per 12 cycles (median).
- First fetch starts in the first PROC cycle.
- frame_done is high in the cycle after the final handshake. in_ready rises the cycle after that.
- Reset in any state takes effect at the next edge:
  - all outputs return to reset values.
  - any partial frame or in-flight pixel is discarded.
  - the next in_valid writes address 0.
- out_ready low never corrupts a held result. out_ready high while out_valid=0 has no effect.

## Test plan
- WIDTH=HEIGHT=4, mode 00, load 0..15, out_ready=1 → outputs 0..15 in order; each out_valid exactly 2 cycles after its fetch start; frame_done pulses once; state sequence LOAD→PROC→DONE→LOAD.
- Mode 01, thresh=8, same frame → 8× 0 then 8× 255. Mode 11 on the same frame → 255,254,…,240.
- Mode 10 on ramp p=4r+c → (0,0) outputs 1, (1,1) outputs 5, (3,3) outputs 14. Second frame all 10 with a single 200 at (2,2) → all 16 outputs 10; each out_valid 11 cycles after its fetch start.
- Backpressure: out_ready low for 5 cycles while out_valid=1 → out_data stable, no new RAM reads. out_ready toggled 1/0 each cycle → all 16 pixels delivered once, none duplicated.
- Reset asserted mid-PROC (after 6 outputs) → next cycle out_valid=0, state=LOAD, in_ready=1; a fresh frame 100..115 reloads from address 0 and passthrough outputs 100..115.
- mode switched from 00 to 10 during PROC → the current frame completes as passthrough; in_valid pulses during PROC do not alter the RAM; the next frame uses median.
